// File: rtl/truth_table_sweeper.sv
// Drives all eight {a,b,c} vectors into the lab logic and captures {x,y} per vector into table_out; STEP_DIV+1 cycles per vector in auto mode.
// Manual stepping via step_btn edge (no backpressure; pulses outside WAIT are dropped); define SWEEPER_DEBOUNCE_EN for a synchronized, debounced button.
module truth_table_sweeper #(
  parameter int unsigned STEP_DIV   = 100000000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode_auto,
  input  logic        step_btn,
  input  logic        x_in,
  input  logic        y_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic [2:0]  vec_idx,
  output logic [15:0] table_out,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  // Out-of-range parameters leave the sweeper inert rather than misbehaving.
  localparam bit PARAMS_OK = (STEP_DIV >= 2) && (DEB_CYCLES >= 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   vec_q, vec_d;
  logic [15:0]  tbl_q, tbl_d;
  logic [CNT_W-1:0] dwell_q;
  logic         btn_rise;
  logic         auto_fire;
  logic         advance;

`ifdef SWEEPER_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic             btn_s1, btn_s2, btn_deb, btn_prev;
  logic [DEB_W-1:0] deb_cnt;

  // Conditioned level only follows the synchronized input after DEB_CYCLES identical samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_deb  <= 1'b0;
      btn_prev <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_s1   <= step_btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_deb;
      if (btn_s2 == btn_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        btn_deb <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign btn_rise = btn_deb & ~btn_prev;
`else
  logic btn_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= step_btn;
    end
  end

  assign btn_rise = step_btn & ~btn_prev;
`endif

  assign auto_fire = mode_auto && (dwell_q == CNT_LAST);
  assign advance   = PARAMS_OK && (mode_auto ? auto_fire : btn_rise);

  // Dwell counter idles at zero outside WAIT so every vector gets a full STEP_DIV dwell.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else if (state_q != ST_WAIT || !mode_auto || auto_fire) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      tbl_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      tbl_q   <= tbl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    tbl_d   = tbl_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          tbl_d   = '0;
          vec_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (advance) begin
          tbl_d[{vec_q, 1'b0} +: 2] = {x_in, y_in};
          if (vec_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + 3'd1;
            state_d = ST_SETTLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign {a, b, c}  = vec_q;
  assign vec_idx    = vec_q;
  assign table_out  = tbl_q;
  assign busy       = (state_q == ST_SETTLE) || (state_q == ST_WAIT);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (STEP_DIV=4, DEB_CYCLES=5); inputs change 1 time unit after each rising edge.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n, start, mode_auto, step_btn, use_ones;
  logic        x_in, y_in;
  logic        a, b, c;
  logic [2:0]  vec_idx;
  logic [15:0] table_out;
  logic        busy, done;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Reference lab logic, or constant ones for the restart scenario.
  assign x_in = use_ones ? 1'b1 : (~c ^ (a | b));
  assign y_in = use_ones ? 1'b1 : ((a | b) & (~(a & b) ^ (a | b)));

  truth_table_sweeper #(.STEP_DIV(4), .DEB_CYCLES(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode_auto (mode_auto),
    .step_btn  (step_btn),
    .x_in      (x_in),
    .y_in      (y_in),
    .a         (a),
    .b         (b),
    .c         (c),
    .vec_idx   (vec_idx),
    .table_out (table_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    chk("done_reached", done, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode_auto = 1'b1; step_btn = 1'b0; use_ones = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_vec", vec_idx, 0);
    chk("rst_table", table_out, 0);
    chk("rst_flags", {busy, done}, 0);
    chk("rst_abc", {a, b, c}, 0);

    // Auto sweep; a start request mid-sweep must be ignored.
    start = 1'b1;
    tick(1);                       // E0
    start = 1'b0;
    chk("e0_busy", busy, 1);
    chk("e0_abc", {a, b, c}, 0);
    tick(5);                       // E0+5: vector 0 captured
    chk("auto_v1", vec_idx, 1);
    chk("auto_t1", table_out, 16'h0002);
    tick(2);
    start = 1'b1;
    tick(1);                       // E0+8
    start = 1'b0;
    chk("start_ignored", {busy, vec_idx}, {1'b1, 3'd1});
    tick(31);                      // E0+39
    chk("auto_not_done", {done, busy, vec_idx}, {1'b0, 1'b1, 3'd7});
    tick(1);                       // E0+40
    chk("auto_done", {done, busy}, {1'b1, 1'b0});
    chk("auto_table", table_out, 16'hD882);
    chk("auto_abc", {a, b, c}, 3'b111);

`ifndef SWEEPER_DEBOUNCE_EN
    // Manual sweep with one-cycle pulses four cycles apart.
    mode_auto = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);                       // now in WAIT
    for (int i = 0; i < 8; i++) begin
      step_btn = 1'b1;
      tick(1);
      step_btn = 1'b0;
      chk("man_vec", vec_idx, (i < 7) ? i + 1 : 7);
      tick(3);
    end
    chk("man_table", table_out, 16'hD882);
    chk("man_done", done, 1);
    step_btn = 1'b1;
    tick(1);
    step_btn = 1'b0;
    tick(1);
    chk("ninth_pulse", {done, busy, vec_idx, table_out}, {1'b1, 1'b0, 3'd7, 16'hD882});

    // Pulse confined to the SETTLE cycle is dropped; then finish in auto mode.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    step_btn = 1'b1;
    chk("restart_clear", table_out, 0);
    tick(1);
    step_btn = 1'b0;
    tick(2);
    chk("settle_pulse", {busy, vec_idx, table_out}, {1'b1, 3'd0, 16'h0000});
    mode_auto = 1'b1;
    wait_done(100);
    chk("mode_switch_table", table_out, 16'hD882);
`else
    // Bouncing button never advances; a held press advances once after 8 edges.
    mode_auto = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      step_btn = 1'b1;
      tick(2);
      step_btn = 1'b0;
      tick(2);
    end
    chk("bounce_no_adv", {vec_idx, table_out}, {3'd0, 16'h0000});
    step_btn = 1'b1;
    tick(7);
    chk("deb_early", vec_idx, 0);
    tick(1);
    chk("deb_adv", {vec_idx, table_out}, {3'd1, 16'h0002});
    tick(2);
    step_btn = 1'b0;
    tick(10);
    chk("deb_single", vec_idx, 1);
    mode_auto = 1'b1;
    wait_done(100);
    chk("deb_table", table_out, 16'hD882);
`endif

    // Reset mid-sweep at vector 5, then a clean sweep.
    mode_auto = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(27);
    chk("mid_vec", vec_idx, 5);
    chk("mid_table", table_out, 16'h0082);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst", {a, b, c, vec_idx, table_out, busy, done}, 0);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_idle", {busy, done, vec_idx}, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(39);
    chk("clean_not_done", done, 0);
    tick(1);
    chk("clean_done", {done, table_out}, {1'b1, 16'hD882});

    // Restart from DONE with x_in = y_in = 1.
    use_ones = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("ones_clear", {table_out, vec_idx, done}, 0);
    tick(39);
    chk("ones_not_done", done, 0);
    tick(1);
    chk("ones_done", {done, table_out}, {1'b1, 16'hFFFF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Stimulus-and-capture stage for the 3-input combinational lab logic (inputs a, b, c; outputs x, y). It drives all eight {a,b,c} combinations in ascending order into the logic block and captures the returned x/y pair for each vector into a 16-bit truth-table register. Stepping is automatic (timed by a divider) or manual (board push-button). `busy` and `done` flags let board LEDs or a bench track progress.

## Interface
- `STEP_DIV`, default 100000000 — auto-mode dwell, in clock cycles, per vector after settle; legal range ≥ 2.
- `DEB_CYCLES`, default 1000000 — consecutive stable samples required on `step_btn`; used only with the debounce option; legal range ≥ 1.
- `clk`  in  1  — single system clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset; synchronous, active-low.
- `start`  in  1  — level-sampled start request; acted on only in IDLE or DONE.
- `mode_auto`  in  1  — 1 selects divider stepping; 0 selects `step_btn` stepping.
- `step_btn`  in  1  — manual advance button.
- `x_in`, `y_in`  in  1 each  — results returned by the logic block.
- `a`, `b`, `c`  out  1 each  — registered stimulus; {a,b,c} = `vec_idx`, with a as MSB.
- `vec_idx`  out  3  — current vector index.
- `table_out`  out  16  — captured results; bit 2i+1 = x and bit 2i = y for vector i.
- `busy`  out  1  — high in SETTLE and WAIT.
- `done`  out  1  — high in DONE.

## Operation
- States: IDLE, SETTLE, WAIT, DONE.
- IDLE: `vec_idx` = 0, `busy` = 0, `done` = 0. `start` = 1 → clear `table_out` to 0, set `vec_idx` = 0, go to SETTLE.
- SETTLE: lasts exactly one cycle, then goes to WAIT. Advance events are ignored here. This guarantees one full cycle of stable stimulus before any capture.
- WAIT: an advance event does the following:
  - Writes {x_in,y_in} into `table_out[2*vec_idx +: 2]`.
  - If `vec_idx` = 7, goes to DONE with `vec_idx` held at 7.
  - Otherwise increments `vec_idx` and goes to SETTLE.
- DONE: `table_out`, `vec_idx` and stimulus are held. `start` = 1 → same action as from IDLE (restart).
- `start` in SETTLE or WAIT is ignored.
- Auto advance:
  - Dwell counter, width `$clog2(STEP_DIV)`, counts only in WAIT with `mode_auto` = 1.
  - Cleared on entering WAIT and whenever `mode_auto` = 0.
  - Advance fires in the cycle where counter = `STEP_DIV`−1.
- Manual advance: a single-cycle pulse derived from a rising edge of the conditioned `step_btn`. A pulse that arrives outside WAIT is dropped, not queued.
- Changing `mode_auto` mid-sweep takes effect next cycle. Captured entries are never modified by a mode change.
- Reset, including mid-sweep: state = IDLE, and all of the following go to 0: `a`, `b`, `c`, `vec_idx`, `table_out`, `busy`, `done`, the dwell counter and button state.

## Timing
- Let E0 be the edge that samples `start` = 1 in IDLE.
- After E0: state = SETTLE and {a,b,c} = 000.
- Auto mode, cost per vector: one SETTLE cycle plus `STEP_DIV` WAIT cycles = `STEP_DIV`+1 cycles.
- Auto mode, total: `done` rises after edge E0 + 8·(`STEP_DIV`+1).
- Capture samples `x_in`/`y_in` at the advancing edge. Captured data appears on `table_out` after that edge.
- The logic block is purely combinational, so `x_in`/`y_in` are valid one cycle after a, b, c change.

## Configuration
- `SWEEPER_DEBOUNCE_EN` defined:
  - `step_btn` passes through a 2-flop synchronizer.
  - The synchronized value then feeds a stability counter that updates the conditioned level only after `DEB_CYCLES` consecutive identical samples.
  - Edge detection runs on the conditioned level.
  - Worst-case press-to-advance latency = 2 + `DEB_CYCLES` + 1 cycles.
- Not defined:
  - `step_btn` is treated as synchronous and bounce-free; one register is used for edge detection.
  - Advance pulses in the cycle after the first high sample that follows a low sample.
  - `DEB_CYCLES` is unused.

## Test plan
- Auto sweep, `STEP_DIV`=4, `x_in`/`y_in` driven by the reference logic (x = ~c^(a|b), y = (a|b)&(~(a&b)^(a|b))), `start` pulse → `done` rises after E0+40, `table_out` = 16'hD882, `busy` low once `done` is high.
- Manual sweep without the macro: 8 one-cycle `step_btn` pulses, each at least 3 cycles apart → `vec_idx` steps 0→7, `table_out` = 16'hD882. A ninth pulse in DONE leaves all outputs unchanged.
- Pulse during SETTLE: `step_btn` high only in the SETTLE cycle → no capture, `vec_idx` unchanged.
- Reset mid-sweep at `vec_idx`=5 → next cycle all outputs 0, state IDLE. A subsequent `start` gives a clean full sweep ending in 16'hD882.
- Restart from DONE with `x_in`=`y_in`=1 held constant → `table_out` cleared at restart, then 16'hFFFF at `done`.
- With `SWEEPER_DEBOUNCE_EN`, `DEB_CYCLES`=5:
  - `step_btn` toggles every 2 cycles for 20 cycles → no advance.
  - `step_btn` then held high for 10 cycles → exactly one advance, 8 cycles after the final rising edge.
